// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one full-adder cell per clock, LSB first
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic load;
    logic last_bit;

    // Full-adder cell fed from the low bits of the operand shift registers.
    logic cell_x, cell_y, cell_c, cell_s, cell_cy;
    assign cell_x  = op_a[0];
    assign cell_y  = op_b[0];
    assign cell_c  = carry;
    assign cell_s  = cell_x ^ cell_y ^ cell_c;
    assign cell_cy = (cell_x & cell_y) | (cell_x & cell_c) | (cell_y & cell_c);

    assign last_bit = (cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; a start is only honoured outside RUN.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand load, one cell step per RUN cycle, and final flag capture on the MSB step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            result <= {cell_s, result[WIDTH-1:1]};
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            carry  <= cell_cy;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                // Signed overflow: carry into the MSB differs from carry out of it.
                cout <= cell_cy;
                ovf  <= cell_c ^ cell_cy;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub
module tb_serial_addsub;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks;
    int failures;

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] r, output logic co, output logic ov);
        int ua, ub, sa, sb, sres, ures;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            ures = ua - ub;
            sres = sa - sb;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            co   = (ures > MASK);
        end
        r  = W'(ures & MASK);
        ov = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    endtask

    // Present one request, let it be accepted, then wait for done counting busy cycles.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                          input string tag);
        logic [W-1:0] er;
        logic         ec, eo;
        int           edges, busy_cnt;
        a = oa; b = ob; sub = os; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; busy_cnt = 0;
        while (!done && edges < 4 * W) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        model(oa, ob, os, er, ec, eo);
        check({tag, "_latency"}, 32'(edges), 32'(W));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_result_held"}, 32'(result), 32'(er));
    endtask

    initial begin
        int dn, edges, d1, d2;
        logic [W-1:0] er;
        logic         ec, eo;
        checks = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the plan; expectations come from the model, plus literal spot checks.
        run_op(8'h3C, 8'h5A, 1'b0, "add_3c_5a");
        check("add_3c_5a_lit", 32'({result, cout, ovf}), 32'({8'h96, 1'b0, 1'b1}));
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        check("add_ff_01_lit", 32'({result, cout, ovf}), 32'({8'h00, 1'b1, 1'b0}));
        run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
        check("add_7f_01_lit", 32'({result, cout, ovf}), 32'({8'h80, 1'b0, 1'b1}));
        run_op(8'h05, 8'h07, 1'b1, "sub_05_07");
        check("sub_05_07_lit", 32'({result, cout, ovf}), 32'({8'hFE, 1'b0, 1'b0}));
        run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
        check("sub_80_01_lit", 32'({result, cout, ovf}), 32'({8'h7F, 1'b1, 1'b1}));

        // A start pulse during RUN must be ignored.
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0;
        repeat (3 * W) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        check("ignore_done_count", 32'(dn), 32'd1);
        check("ignore_result", 32'(result), 32'h30);
        check("ignore_cout", 32'(cout), 32'd0);

        // Back-to-back: start held high, second operands presented during DONE.
        a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        edges = 0; d1 = -1; d2 = -1;
        while (edges < 4 * W && d2 < 0) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = edges;
                    check("b2b_first_result", 32'(result), 32'h03);
                    a = 8'h0F; b = 8'h01; sub = 1'b1;
                end else begin
                    d2 = edges;
                    start = 1'b0;
                    check("b2b_second_result", 32'(result), 32'h0E);
                end
            end
        end
        start = 1'b0;
        check("b2b_first_done_edge", 32'(d1), 32'(W));
        check("b2b_second_done_edge", 32'(d2), 32'(2 * W + 1));
        @(posedge clk); #1;

        // Asynchronous reset in the 4th RUN cycle clears everything at once.
        a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'h01, 8'h01, 1'b0, "after_rst");
        check("after_rst_lit", 32'(result), 32'h02);

        // Randomized operations against the reference model, including edge operands.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            if (i % 10 == 0) ra = 8'h80;
            if (i % 10 == 1) rb = 8'hFF;
            run_op(ra, rb, rs, "rand");
        end

        model(8'h00, 8'h00, 1'b1, er, ec, eo);
        run_op(8'h00, 8'h00, 1'b1, "sub_zero");
        check("sub_zero_no_borrow", 32'(cout), 32'(ec));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
